// File: rtl/store_buffer_queue.sv
// Age-ordered store buffer: circular FIFO with byte-merged load forwarding and a flush FSM.
// Build option: define STORE_BUFFER_COALESCE_EN to merge same-line/same-way pushes into the youngest entry.
module store_buffer_queue #(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int WAY_W       = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic [DATA_W-1:0]             push_data,
    input  logic [DATA_W/8-1:0]           push_be,
    input  logic [WAY_W-1:0]              push_way,
    output logic                          drain_valid,
    input  logic                          drain_ready,
    output logic [ADDR_W-1:0]             drain_addr,
    output logic [DATA_W-1:0]             drain_data,
    output logic [DATA_W/8-1:0]           drain_be,
    output logic [WAY_W-1:0]              drain_way,
    input  logic                          lookup_valid,
    input  logic [ADDR_W-1:0]             lookup_addr,
    output logic                          lookup_hit,
    output logic [DATA_W/8-1:0]           lookup_be,
    output logic [DATA_W-1:0]             lookup_data,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic [$clog2(NUM_ENTRIES):0]  count,
    output logic                          empty,
    output logic                          full,
    output logic [1:0]                    o_dbg_state
);

    localparam int NB   = DATA_W / 8;
    localparam int LOFF = $clog2(NB);
    localparam int IW   = $clog2(NUM_ENTRIES);
    localparam int PW   = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising clock edge when valid && ready are both high;
    // valid never depends on ready, and the payload is held stable while valid waits for ready.

    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [ADDR_W-1:0] r_addr [NUM_ENTRIES];
    logic [DATA_W-1:0] r_data [NUM_ENTRIES];
    logic [NB-1:0]     r_be   [NUM_ENTRIES];
    logic [WAY_W-1:0]  r_way  [NUM_ENTRIES];
    state_t            r_state;
    logic              r_flush_done;

    logic [IW-1:0]     w_head_idx;
    logic [IW-1:0]     w_tail_idx;
    logic              w_empty;
    logic              w_full;
    logic              w_drain;
    logic              w_push;
    logic              w_coal;
    logic              w_alloc;
    logic [IW-1:0]     w_lk_idx;
    logic [NB-1:0]     w_lk_be;
    logic [DATA_W-1:0] w_lk_data;
    logic              w_unused;

    assign w_head_idx = r_head[IW-1:0];
    assign w_tail_idx = r_tail[IW-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IW] != r_tail[IW]);
    assign w_drain    = !w_empty && drain_ready;
    assign w_unused   = ^lookup_addr[LOFF-1:0];

`ifdef STORE_BUFFER_COALESCE_EN
    logic [IW-1:0] w_last_idx;
    assign w_last_idx = w_tail_idx - IW'(1);
    // The youngest entry cannot absorb a push while it is leaving as the head.
    assign w_coal = r_valid[w_last_idx]
                 && (r_addr[w_last_idx][ADDR_W-1:LOFF] == push_addr[ADDR_W-1:LOFF])
                 && (r_way[w_last_idx] == push_way)
                 && !(w_drain && (w_last_idx == w_head_idx));
    assign push_ready = (r_state == S_IDLE) && (!w_full || w_coal);
`else
    assign w_coal     = 1'b0;
    assign push_ready = (r_state == S_IDLE) && !w_full;
`endif

    assign w_push  = push_valid && push_ready;
    assign w_alloc = w_push && !w_coal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
        end else begin
            if (w_alloc) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_tail              <= r_tail + PTR_ONE;
            end
            if (w_drain) begin
                r_valid[w_head_idx] <= 1'b0;
                r_head              <= r_head + PTR_ONE;
            end
        end
    end

    // Payload storage needs no reset; r_valid qualifies every use of it.
    always_ff @(posedge clock) begin
        if (w_alloc) begin
            r_addr[w_tail_idx] <= push_addr;
            r_data[w_tail_idx] <= push_data;
            r_be[w_tail_idx]   <= push_be;
            r_way[w_tail_idx]  <= push_way;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        else if (w_push && w_coal) begin
            r_be[w_last_idx] <= r_be[w_last_idx] | push_be;
            for (int b = 0; b < NB; b++) begin
                if (push_be[b]) begin
                    r_data[w_last_idx][8*b +: 8] <= push_data[8*b +: 8];
                end
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_flush_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_flush_done <= 1'b0;
                    if (flush_req) r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (w_empty) begin
                        r_state      <= S_DONE;
                        r_flush_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_flush_done <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_flush_done <= 1'b0;
                end
            endcase
        end
    end

    // Walk oldest to youngest so a younger matching byte overwrites an older one.
    always_comb begin
        w_lk_be   = '0;
        w_lk_data = '0;
        w_lk_idx  = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            w_lk_idx = w_head_idx + IW'(k);
            if (lookup_valid && r_valid[w_lk_idx]
                && (r_addr[w_lk_idx][ADDR_W-1:LOFF] == lookup_addr[ADDR_W-1:LOFF])) begin
                for (int b = 0; b < NB; b++) begin
                    if (r_be[w_lk_idx][b]) begin
                        w_lk_be[b]             = 1'b1;
                        w_lk_data[8*b +: 8]    = r_data[w_lk_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign lookup_be   = w_lk_be;
    assign lookup_data = w_lk_data;
    assign lookup_hit  = |w_lk_be;

    assign drain_valid = !w_empty;
    assign drain_addr  = r_addr[w_head_idx];
    assign drain_data  = r_data[w_head_idx];
    assign drain_be    = r_be[w_head_idx];
    assign drain_way   = r_way[w_head_idx];

    assign count       = r_tail - r_head;
    assign empty       = w_empty;
    assign full        = w_full;
    assign flush_done  = r_flush_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_store_buffer_queue.sv
// Randomized and directed bench for store_buffer_queue against a queue-based reference model.
module tb_store_buffer_queue;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int NB = DW / 8;
    localparam int WW = 2;
    localparam int EW = WW + NB + DW + AW;

    typedef struct packed {
        logic [WW-1:0] way;
        logic [NB-1:0] be;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } ent_t;

    logic          clock;
    logic          reset;
    logic          push_valid;
    logic          push_ready;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_data;
    logic [NB-1:0] push_be;
    logic [WW-1:0] push_way;
    logic          drain_valid;
    logic          drain_ready;
    logic [AW-1:0] drain_addr;
    logic [DW-1:0] drain_data;
    logic [NB-1:0] drain_be;
    logic [WW-1:0] drain_way;
    logic          lookup_valid;
    logic [AW-1:0] lookup_addr;
    logic          lookup_hit;
    logic [NB-1:0] lookup_be;
    logic [DW-1:0] lookup_data;
    logic          flush_req;
    logic          flush_done;
    logic [3:0]    count;
    logic          empty;
    logic          full;
    logic [1:0]    o_dbg_state;

    logic [EW-1:0] exp_q[$];
    int            m_phase;   // 0 idle, 1 flushing, 2 done pulse
    int            n_tests;
    int            n_fail;

    store_buffer_queue #(.NUM_ENTRIES(N), .ADDR_W(AW), .DATA_W(DW), .WAY_W(WW)) dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
        .push_data(push_data), .push_be(push_be), .push_way(push_way),
        .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
        .drain_data(drain_data), .drain_be(drain_be), .drain_way(drain_way),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
        .lookup_be(lookup_be), .lookup_data(lookup_data),
        .flush_req(flush_req), .flush_done(flush_done),
        .count(count), .empty(empty), .full(full), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill_bytes(input logic [7:0] v);
        logic [DW-1:0] r;
        for (int b = 0; b < NB; b++) r[8*b +: 8] = v;
        return r;
    endfunction

    // One clock: drive at negedge, compare against the model, then advance the model.
    task automatic cycle(input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic [NB-1:0] pb, input logic [WW-1:0] pw, input logic dr,
                         input logic lv, input logic [AW-1:0] la, input logic fr);
        int            sz;
        bit            m_drain;
        bit            m_coal;
        bit            m_pr;
        bit            found;
        ent_t          e;
        ent_t          front;
        logic [NB-1:0] lbe;
        logic [DW-1:0] ldat;
        @(negedge clock);
        push_valid = pv; push_addr = pa; push_data = pd; push_be = pb; push_way = pw;
        drain_ready = dr; lookup_valid = lv; lookup_addr = la; flush_req = fr;
        #1;
        sz      = exp_q.size();
        m_drain = (sz > 0) && dr;
        m_coal  = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
        if (sz > 0) begin
            e = exp_q[sz-1];
            if (e.addr[AW-1:4] == pa[AW-1:4] && e.way == pw && !(sz == 1 && m_drain)) m_coal = 1'b1;
        end
`endif
        m_pr = (m_phase == 0) && (sz < N || m_coal);

        check_eq("push_ready", push_ready, m_pr);
        check_eq("drain_valid", drain_valid, sz > 0);
        check_eq("count", count, sz);
        check_eq("empty", empty, sz == 0);
        check_eq("full", full, sz == N);
        check_eq("flush_done", flush_done, m_phase == 2);
        if (sz > 0) begin
            front = exp_q[0];
            check_eq("drain_addr", drain_addr, front.addr);
            check_eq("drain_data", drain_data, front.data);
            check_eq("drain_be", drain_be, front.be);
            check_eq("drain_way", drain_way, front.way);
        end

        // For each byte, the youngest store to the line that enables it supplies it.
        lbe  = '0;
        ldat = '0;
        if (lv) begin
            for (int b = 0; b < NB; b++) begin
                found = 1'b0;
                for (int i = sz - 1; i >= 0; i--) begin
                    e = exp_q[i];
                    if (!found && e.addr[AW-1:4] == la[AW-1:4] && e.be[b]) begin
                        found = 1'b1;
                        lbe[b] = 1'b1;
                        ldat[8*b +: 8] = e.data[8*b +: 8];
                    end
                end
            end
        end
        check_eq("lookup_hit", lookup_hit, |lbe);
        check_eq("lookup_be", lookup_be, lbe);
        check_eq("lookup_data", lookup_data, ldat);

        if (pv && m_pr) begin
            if (m_coal) begin
                e = exp_q[sz-1];
                for (int b = 0; b < NB; b++) if (pb[b]) e.data[8*b +: 8] = pd[8*b +: 8];
                e.be = e.be | pb;
                exp_q[sz-1] = e;
            end else begin
                e.addr = pa; e.data = pd; e.be = pb; e.way = pw;
                exp_q.push_back(e);
            end
        end
        if (m_drain) void'(exp_q.pop_front());
        case (m_phase)
            0: if (fr) m_phase = 1;
            1: if (sz == 0) m_phase = 2;
            default: m_phase = 0;
        endcase
    endtask

    task automatic idle_cycle(input logic dr);
        cycle(1'b0, '0, '0, '0, '0, dr, 1'b0, '0, 1'b0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 12; i++) begin
            if (exp_q.size() != 0) idle_cycle(1'b1);
        end
        idle_cycle(1'b0);
        check_eq("drained_empty", empty, 1'b1);
    endtask

    initial begin
        int pulses;
        n_tests = 0; n_fail = 0; m_phase = 0;
        reset = 1'b1;
        push_valid = 0; push_addr = '0; push_data = '0; push_be = '0; push_way = '0;
        drain_ready = 0; lookup_valid = 1; lookup_addr = 32'h100; flush_req = 0;
        #12;
        check_eq("rst_empty", empty, 1'b1);
        check_eq("rst_full", full, 1'b0);
        check_eq("rst_count", count, 0);
        check_eq("rst_drain_valid", drain_valid, 1'b0);
        check_eq("rst_flush_done", flush_done, 1'b0);
        check_eq("rst_lookup_hit", lookup_hit, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // fill to full, then drain in order
        for (int i = 0; i < N; i++)
            cycle(1'b1, 32'h100 + 32'(16*i), fill_bytes(8'(i + 1)), 16'h00FF, 2'd1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 32'h180, '0, 16'hFFFF, 2'd0, 1'b0, 1'b0, '0, 1'b0);
        check_eq("fill_full", full, 1'b1);
        check_eq("fill_push_ready", push_ready, 1'b0);
        check_eq("fill_count", count, 8);

        // push into the youngest line/way while full
        cycle(1'b1, 32'h170, fill_bytes(8'hAB), 16'h0100, 2'd1, 1'b0, 1'b0, '0, 1'b0);
`ifdef STORE_BUFFER_COALESCE_EN
        check_eq("coal_push_ready", push_ready, 1'b1);
`else
        check_eq("coal_push_ready", push_ready, 1'b0);
`endif
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 32'h174, 1'b0);
        check_eq("coal_count", count, 8);
`ifdef STORE_BUFFER_COALESCE_EN
        check_eq("coal_lookup_be", lookup_be, 16'h01FF);
`else
        check_eq("coal_lookup_be", lookup_be, 16'h00FF);
`endif
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
            check_eq("drain_order", drain_addr, 32'h100 + 32'(16*i));
        end
        idle_cycle(1'b0);
        check_eq("drain_empty", empty, 1'b1);

        // byte-merged forwarding
        cycle(1'b1, 32'h200, fill_bytes(8'h11), 16'h000F, 2'd0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 32'h204, fill_bytes(8'h22), 16'h00F0, 2'd0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 32'h200, fill_bytes(8'h33), 16'h0003, 2'd0, 1'b0, 1'b1, 32'h208, 1'b0);
        check_eq("fwd_before_c_be", lookup_be, 16'h00FF);
        check_eq("fwd_before_c_data", lookup_data, 128'h2222_2222_1111_1111);
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 32'h208, 1'b0);
        check_eq("fwd_hit", lookup_hit, 1'b1);
        check_eq("fwd_be", lookup_be, 16'h00FF);
        check_eq("fwd_data", lookup_data, 128'h2222_2222_1111_3333);
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 32'h308, 1'b0);
        check_eq("fwd_miss", lookup_hit, 1'b0);
        drain_all();

        // steady push+drain at count 4 with pointer wrap
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h400 + 32'(16*i), fill_bytes(8'(8'h40 + i)), 16'hFFFF, 2'd2, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 32'h500 + 32'(16*i), fill_bytes(8'(8'h50 + i)), 16'(i + 1), 2'(i), 1'b1,
                  1'b1, 32'h500 + 32'(16*(i % 6)), 1'b0);
        idle_cycle(1'b0);
        check_eq("steady_count", count, 4);
        drain_all();

        // flush with 3 entries, then flush on an empty buffer
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h600 + 32'(16*i), fill_bytes(8'h66), 16'hFFFF, 2'd0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'h700 + 32'(16*i), fill_bytes(8'h77), 16'hFFFF, 2'd0, 1'b1, 1'b0, '0, 1'b0);
            if (flush_done) pulses++;
        end
        check_eq("flush_pulses", pulses, 1);
        drain_all();
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        idle_cycle(1'b0);
        check_eq("eflush_not_yet", flush_done, 1'b0);
        idle_cycle(1'b0);
        check_eq("eflush_done", flush_done, 1'b1);
        idle_cycle(1'b0);
        check_eq("eflush_cleared", flush_done, 1'b0);

        // asynchronous reset with 5 entries held
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h800 + 32'(16*i), fill_bytes(8'h88), 16'hFFFF, 2'd3, 1'b0, 1'b0, '0, 1'b0);
        idle_cycle(1'b0);
        check_eq("prerst_count", count, 5);
        #2;
        lookup_valid = 1'b1; lookup_addr = 32'h810;
        reset = 1'b1;
        #1;
        check_eq("arst_empty", empty, 1'b1);
        check_eq("arst_drain_valid", drain_valid, 1'b0);
        check_eq("arst_count", count, 0);
        check_eq("arst_lookup_hit", lookup_hit, 1'b0);
        exp_q.delete();
        m_phase = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // randomized traffic over a few shared lines
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 99) < 60,
                  32'h300 + 32'(16 * $urandom_range(0, 3)) + 32'($urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 2'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 70,
                  32'h300 + 32'(16 * $urandom_range(0, 4)) + 32'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 3);
        end
        drain_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
